lock_indicator: RTL and testbench
=================================

Name: lock_indicator

Overview:
- Output side of the door-lock state interface: consumes the 3-bit state code and drives the user-facing indicators.
- Drives the LEDs, the piezo beep sequences and the lockout countdown.
- Sits between the state manager and the board pins or 7-segment driver.
- Converts state transitions into timed beep patterns, and enforces the timed lock period with an expiry pulse.

Parameters:
- TICK_DIV, 50000, clk cycles per timing tick.
- SHORT_TICKS, 10, ticks per short beep.
- LONG_TICKS, 40, ticks per long beep.
- GAP_TICKS, 10, silent ticks between beeps.
- TICKS_PER_SEC, 20, ticks per countdown second.
- BLINK_TICKS, 5, ticks per led_lock blink half-period.
- LOCK_SECS, 30, lockout length in seconds (max 63).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- state  in  3  state code: 000 off, 001 on, 010 wrong1, 011 wrong2, 100 answer, 101 reset, 111 lock; 110 is invalid.
- led_on  out  1  high when the state is not off and not invalid.
- led_open  out  1  high in 100.
- led_wrong  out  2  01 in wrong1, 11 in wrong2, 00 otherwise.
- led_lock  out  1  blinks while in lock and the countdown is nonzero.
- buzzer  out  1  piezo drive.
- lock_remaining  out  6  seconds left in the lockout; 0 when not counting.
- lock_expired  out  1  one-cycle pulse when the countdown reaches 0.

Behaviour:
- Reset (async, rst=1): all outputs 0. state_q and prev_q are cleared to 000, all counters to 0, and the sequencer goes to IDLE.
- Input path: state is registered into state_q every cycle; prev_q <= state_q.
- Event: state_q != prev_q. The block reacts only to events; a held state never retriggers.
- Latency: an input change at edge N reaches state_q at N and is detected at N+1; buzzer goes high at edge N+2.
- Prescaler counts 0..TICK_DIV-1 and emits a tick when the count is TICK_DIV-1. It is cleared on every event, so all durations are exact multiples of TICK_DIV.
- Beep patterns by the new state:
  - 001: 1 short beep.
  - 010 and 011: 2 short beeps.
  - 100: 1 long beep.
  - 101: 3 short beeps.
  - 111: continuous buzzer until the countdown expires.
  - 000 and 110: silence.
- Beep sequencer FSM states: IDLE, BEEP, GAP, ALARM.
  - An event loads beeps_left and the duration, then enters BEEP, or ALARM for 111, or IDLE for silent states.
  - BEEP: buzzer=1 for the duration in ticks. Then go to GAP if beeps_left>1, else IDLE.
  - GAP: buzzer=0 for GAP_TICKS, then BEEP with beeps_left decremented.
  - ALARM: buzzer=1 until expiry or an event.
- Event mid-pattern: the current pattern is aborted and the new pattern starts from its beginning. buzzer may stay 1 across the boundary if the new pattern also starts with a beep.
- Lock countdown:
  - Entry into 111 loads lock_remaining=LOCK_SECS and clears the sub-second tick counter.
  - Each TICKS_PER_SEC ticks, lock_remaining decrements.
  - On the 1->0 transition, lock_expired pulses for exactly one cycle, ALARM goes to IDLE (buzzer 0) and led_lock goes to 0.
  - The block stays in 111 silently until the state changes.
- Leaving 111 before expiry: lock_remaining is cleared to 0 with no lock_expired pulse.
- Re-entry into 111: the countdown reloads to the full LOCK_SECS.
- led_lock:
  - Starts at 1 on lock entry and toggles every BLINK_TICKS while lock_remaining != 0.
  - Forced to 0 otherwise.
- led_on, led_open and led_wrong are registered decodes of state_q.
- Invalid code 110 is treated as off: all LEDs 0, buzzer 0.
- Counters saturate or hold and never wrap. lock_remaining never underflows past 0.

Decomposition:
- Shared package lock_pkg:
  - State code constants ST_OFF, ST_ON, ST_WRONG1, ST_WRONG2, ST_ANSWER, ST_RESET, ST_LOCK.
  - Beep sequencer state encoding.
  - Tick and duration counter widths.
- One sub-module: tick_gen (prescaler with sync clear, outputs a one-cycle tick), reused by the keypad debouncer.

Test Plan:
All tests use TICK_DIV=4, SHORT_TICKS=2, LONG_TICKS=6, GAP_TICKS=2, TICKS_PER_SEC=5, BLINK_TICKS=1, LOCK_SECS=3.
1. state 000->001 at cycle 10 -> buzzer=1 on cycles 12..19 (8 cycles), then 0; led_on=1 from cycle 11.
2. state 001->010 -> two 8-cycle beeps separated by 8 cycles low; led_wrong=01; holding 010 for 200 cycles gives no further beeps.
3. state 011->111 at cycle T:
   - Outputs: lock_remaining=3 at T+2; 2 at T+22; 1 at T+42; 0 with lock_expired=1 for one cycle at T+62.
   - buzzer: high from T+2 to T+62, low after.
   - led_lock: toggles every 4 cycles during the countdown.
4. state 111->000 at T+30 (mid-lock) -> lock_remaining=0, buzzer=0 and led_lock=0 within 2 cycles; no lock_expired pulse ever.
5. state ->101, then ->100 after 12 cycles -> the 3-beep pattern is aborted and a 24-cycle long beep starts; total buzzer activity is consistent with the abort.
6. rst asserted mid-ALARM (asynchronously, between edges) -> all outputs 0 immediately. After release with state held at 111, the block re-detects the 000->111 event and restarts the countdown at 3; state 110 -> no beep, no LEDs.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock indicator: state codes, sequencer
// encoding, counter widths and the per-state beep pattern lookup.
package lock_pkg;

    localparam logic [2:0] ST_OFF     = 3'b000;
    localparam logic [2:0] ST_ON      = 3'b001;
    localparam logic [2:0] ST_WRONG1  = 3'b010;
    localparam logic [2:0] ST_WRONG2  = 3'b011;
    localparam logic [2:0] ST_ANSWER  = 3'b100;
    localparam logic [2:0] ST_RESET   = 3'b101;
    localparam logic [2:0] ST_INVALID = 3'b110;
    localparam logic [2:0] ST_LOCK    = 3'b111;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_BEEP  = 2'd1,
        SEQ_GAP   = 2'd2,
        SEQ_ALARM = 2'd3
    } seq_state_t;

    localparam int TICK_W = 16;
    localparam int DUR_W  = 8;
    localparam int SUB_W  = 8;
    localparam int SEC_W  = 6;

    function automatic logic [1:0] beep_count(input logic [2:0] code);
        case (code)
            ST_ON, ST_ANSWER:      return 2'd1;
            ST_WRONG1, ST_WRONG2:  return 2'd2;
            ST_RESET:              return 2'd3;
            default:               return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lock_indicator_tick_gen.sv
// Prescaler: counts 0..DIV-1 and emits a one-cycle tick on the last count.
// A synchronous clear restarts the count so timed intervals start cleanly.
module tick_gen #(
    parameter int DIV = 50000,
    parameter int W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr || cnt_q == LAST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

    assign tick = (cnt_q == LAST) && !clr;
endmodule

// File: rtl/lock_indicator.sv
// Door-lock indicator: decodes the state code into LEDs, plays beep patterns
// on state changes and runs the timed lockout countdown.
//
// state     | meaning
// SEQ_IDLE  | buzzer silent, waiting for a state change
// SEQ_BEEP  | buzzer on for the current beep duration
// SEQ_GAP   | buzzer off between beeps of a multi-beep pattern
// SEQ_ALARM | buzzer on continuously until lockout expiry or a state change
module lock_indicator
    import lock_pkg::*;
#(
    parameter int TICK_DIV      = 50000,
    parameter int SHORT_TICKS   = 10,
    parameter int LONG_TICKS    = 40,
    parameter int GAP_TICKS     = 10,
    parameter int TICKS_PER_SEC = 20,
    parameter int BLINK_TICKS   = 5,
    parameter int LOCK_SECS     = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    output logic             led_on,
    output logic             led_open,
    output logic [1:0]       led_wrong,
    output logic             led_lock,
    output logic             buzzer,
    output logic [SEC_W-1:0] lock_remaining,
    output logic             lock_expired
);
    localparam logic [DUR_W-1:0] SHORT_D   = DUR_W'(SHORT_TICKS);
    localparam logic [DUR_W-1:0] LONG_D    = DUR_W'(LONG_TICKS);
    localparam logic [DUR_W-1:0] GAP_D     = DUR_W'(GAP_TICKS);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SUB_W-1:0] BLNK_LAST = SUB_W'(BLINK_TICKS - 1);
    localparam logic [SEC_W-1:0] SECS_LD   = SEC_W'(LOCK_SECS);

    logic [2:0]       state_q, prev_q;
    logic             evt, tick, expire_now;
    seq_state_t       seq_q, seq_nxt;
    logic [1:0]       beeps_q;
    logic [DUR_W-1:0] dur_q;
    logic             long_q;
    logic [SEC_W-1:0] secs_q;
    logic [SUB_W-1:0] sub_q, blink_cnt_q;
    logic             blink_q, expired_q;

    assign evt = (state_q != prev_q);

    tick_gen #(.DIV(TICK_DIV), .W(TICK_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (evt),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            prev_q  <= ST_OFF;
        end else begin
            state_q <= state;
            prev_q  <= state_q;
        end
    end

    assign expire_now = !evt && tick && secs_q == SEC_W'(1) && sub_q == SUB_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) seq_q <= SEQ_IDLE;
        else     seq_q <= seq_nxt;
    end

    always_comb begin
        seq_nxt = seq_q;
        if (evt) begin
            if (state_q == ST_LOCK)
                seq_nxt = SEQ_ALARM;
            else if (beep_count(state_q) != 2'd0)
                seq_nxt = SEQ_BEEP;
            else
                seq_nxt = SEQ_IDLE;
        end else begin
            case (seq_q)
                SEQ_BEEP:  if (tick && dur_q <= DUR_W'(1))
                               seq_nxt = (beeps_q > 2'd1) ? SEQ_GAP : SEQ_IDLE;
                SEQ_GAP:   if (tick && dur_q <= DUR_W'(1))
                               seq_nxt = SEQ_BEEP;
                SEQ_ALARM: if (expire_now)
                               seq_nxt = SEQ_IDLE;
                default:   seq_nxt = SEQ_IDLE;
            endcase
        end
    end

    // Beep/gap duration counter; an event restarts the pattern from scratch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beeps_q <= '0;
            dur_q   <= '0;
            long_q  <= 1'b0;
        end else if (evt) begin
            beeps_q <= beep_count(state_q);
            long_q  <= (state_q == ST_ANSWER);
            dur_q   <= (state_q == ST_ANSWER) ? LONG_D : SHORT_D;
        end else if (tick && seq_q == SEQ_BEEP) begin
            if (dur_q <= DUR_W'(1))
                dur_q <= GAP_D;
            else
                dur_q <= dur_q - 1'b1;
        end else if (tick && seq_q == SEQ_GAP) begin
            if (dur_q <= DUR_W'(1)) begin
                beeps_q <= beeps_q - 1'b1;
                dur_q   <= long_q ? LONG_D : SHORT_D;
            end else begin
                dur_q <= dur_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            secs_q      <= '0;
            sub_q       <= '0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            expired_q   <= 1'b0;
        end else begin
            expired_q <= expire_now;
            if (evt) begin
                secs_q      <= (state_q == ST_LOCK) ? SECS_LD : '0;
                sub_q       <= '0;
                blink_q     <= (state_q == ST_LOCK);
                blink_cnt_q <= '0;
            end else if (tick && secs_q != '0) begin
                if (sub_q == SUB_LAST) begin
                    sub_q  <= '0;
                    secs_q <= secs_q - 1'b1;
                end else begin
                    sub_q <= sub_q + 1'b1;
                end
                if (blink_cnt_q >= BLNK_LAST) begin
                    blink_cnt_q <= '0;
                    blink_q     <= ~blink_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    // All user-facing outputs are registered copies of the internal state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_on         <= 1'b0;
            led_open       <= 1'b0;
            led_wrong      <= 2'b00;
            led_lock       <= 1'b0;
            buzzer         <= 1'b0;
            lock_remaining <= '0;
            lock_expired   <= 1'b0;
        end else begin
            led_on         <= (state_q != ST_OFF) && (state_q != ST_INVALID);
            led_open       <= (state_q == ST_ANSWER);
            led_wrong      <= (state_q == ST_WRONG1) ? 2'b01 :
                              (state_q == ST_WRONG2) ? 2'b11 : 2'b00;
            led_lock       <= blink_q && (secs_q != '0);
            buzzer         <= (seq_q == SEQ_BEEP) || (seq_q == SEQ_ALARM);
            lock_remaining <= secs_q;
            lock_expired   <= expired_q;
        end
    end
endmodule

// File: tb/tb_lock_indicator.sv
// Directed bench for lock_indicator using small timing parameters so that
// every beep and countdown interval is a handful of clock cycles.
module tb_lock_indicator;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state;
    logic       led_on, led_open, led_lock, buzzer, lock_expired;
    logic [1:0] led_wrong;
    logic [5:0] lock_remaining;

    int total = 0;
    int bad   = 0;

    lock_indicator #(
        .TICK_DIV(4), .SHORT_TICKS(2), .LONG_TICKS(6), .GAP_TICKS(2),
        .TICKS_PER_SEC(5), .BLINK_TICKS(1), .LOCK_SECS(3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .state          (state),
        .led_on         (led_on),
        .led_open       (led_open),
        .led_wrong      (led_wrong),
        .led_lock       (led_lock),
        .buzzer         (buzzer),
        .lock_remaining (lock_remaining),
        .lock_expired   (lock_expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        int         beep_cycles;
        int         expiries;
        logic       on;
        logic       open;
        logic [1:0] wrong;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // advance n rising edges, then settle 2ns past the edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic run_window(input int n, output int hi, output int ex);
        hi = 0;
        ex = 0;
        for (int k = 0; k < n; k++) begin
            cyc(1);
            hi += int'(buzzer);
            ex += int'(lock_expired);
        end
    endtask

    initial begin
        int hi, ex;

        vecs[0] = '{3'b001,  8, 0, 1'b1, 1'b0, 2'b00};
        vecs[1] = '{3'b010, 16, 0, 1'b1, 1'b0, 2'b01};
        vecs[2] = '{3'b011, 16, 0, 1'b1, 1'b0, 2'b11};
        vecs[3] = '{3'b100, 24, 0, 1'b1, 1'b1, 2'b00};
        vecs[4] = '{3'b101, 24, 0, 1'b1, 1'b0, 2'b00};
        vecs[5] = '{3'b111, 60, 1, 1'b1, 1'b0, 2'b00};
        vecs[6] = '{3'b110,  0, 0, 1'b0, 1'b0, 2'b00};
        vecs[7] = '{3'b000,  0, 0, 1'b0, 1'b0, 2'b00};
        vecs[8] = '{3'b001,  8, 0, 1'b1, 1'b0, 2'b00};

        rst   = 1'b1;
        state = 3'b000;
        #2;
        chk("reset_led_on", int'(led_on), 0);
        chk("reset_buzzer", int'(buzzer), 0);
        chk("reset_remaining", int'(lock_remaining), 0);
        cyc(2);
        rst = 1'b0;
        cyc(5);

        // single short beep: state_q changes at edge N
        state = 3'b001;
        cyc(1);
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (i == 1) chk("t1_led_on_n1", int'(led_on), 1);
            if (i == 1) chk("t1_buz_n1", int'(buzzer), 0);
            if (i == 2) chk("t1_buz_n2", int'(buzzer), 1);
            if (i == 9) chk("t1_buz_n9", int'(buzzer), 1);
            if (i == 10) chk("t1_buz_n10", int'(buzzer), 0);
        end
        state = 3'b000;
        cyc(40);

        foreach (vecs[v]) begin
            state = vecs[v].code;
            run_window(80, hi, ex);
            chk($sformatf("vec%0d_beep_cycles", v), hi, vecs[v].beep_cycles);
            chk($sformatf("vec%0d_expiries", v), ex, vecs[v].expiries);
            chk($sformatf("vec%0d_led_on", v), int'(led_on), int'(vecs[v].on));
            chk($sformatf("vec%0d_led_open", v), int'(led_open), int'(vecs[v].open));
            chk($sformatf("vec%0d_led_wrong", v), int'(led_wrong), int'(vecs[v].wrong));
            chk($sformatf("vec%0d_led_lock", v), int'(led_lock), 0);
            chk($sformatf("vec%0d_remaining", v), int'(lock_remaining), 0);
        end

        // held wrong1 never retriggers
        state = 3'b010;
        run_window(80, hi, ex);
        run_window(200, hi, ex);
        chk("hold_w1_no_beeps", hi, 0);

        // full countdown from wrong2
        state = 3'b011;
        cyc(80);
        state = 3'b111;
        cyc(1);
        for (int i = 1; i <= 66; i++) begin
            cyc(1);
            if (i == 1)  chk("lk_rem_n1", int'(lock_remaining), 0);
            if (i == 2)  chk("lk_rem_n2", int'(lock_remaining), 3);
            if (i == 2)  chk("lk_buz_n2", int'(buzzer), 1);
            if (i == 2)  chk("lk_led_n2", int'(led_lock), 1);
            if (i == 5)  chk("lk_led_n5", int'(led_lock), 1);
            if (i == 6)  chk("lk_led_n6", int'(led_lock), 0);
            if (i == 10) chk("lk_led_n10", int'(led_lock), 1);
            if (i == 21) chk("lk_rem_n21", int'(lock_remaining), 3);
            if (i == 22) chk("lk_rem_n22", int'(lock_remaining), 2);
            if (i == 42) chk("lk_rem_n42", int'(lock_remaining), 1);
            if (i == 61) chk("lk_exp_n61", int'(lock_expired), 0);
            if (i == 61) chk("lk_buz_n61", int'(buzzer), 1);
            if (i == 62) chk("lk_rem_n62", int'(lock_remaining), 0);
            if (i == 62) chk("lk_exp_n62", int'(lock_expired), 1);
            if (i == 63) chk("lk_exp_n63", int'(lock_expired), 0);
            if (i == 63) chk("lk_buz_n63", int'(buzzer), 0);
            if (i == 63) chk("lk_led_n63", int'(led_lock), 0);
        end

        // leave lock mid-countdown
        state = 3'b000;
        cyc(40);
        state = 3'b111;
        cyc(1);
        cyc(29);
        state = 3'b000;
        cyc(1);
        cyc(2);
        chk("abort_remaining", int'(lock_remaining), 0);
        chk("abort_buzzer", int'(buzzer), 0);
        chk("abort_led_lock", int'(led_lock), 0);
        run_window(80, hi, ex);
        chk("abort_no_expiry", ex, 0);

        // reset pattern aborted by answer after 12 cycles
        state = 3'b101;
        cyc(1);
        hi = 0;
        for (int i = 1; i <= 60; i++) begin
            if (i == 12) state = 3'b100;
            cyc(1);
            hi += int'(buzzer);
            if (i == 10) chk("ab_buz_n10", int'(buzzer), 0);
            if (i == 14) chk("ab_buz_n14", int'(buzzer), 1);
            if (i == 37) chk("ab_buz_n37", int'(buzzer), 1);
            if (i == 38) chk("ab_buz_n38", int'(buzzer), 0);
        end
        chk("ab_total_beep", hi, 32);

        // async reset in the middle of the alarm
        state = 3'b000;
        cyc(40);
        state = 3'b111;
        cyc(20);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_buzzer", int'(buzzer), 0);
        chk("ar_led_on", int'(led_on), 0);
        chk("ar_remaining", int'(lock_remaining), 0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        chk("ar_rel_n2_buz", int'(buzzer), 0);
        cyc(1);
        chk("ar_rel_n3_rem", int'(lock_remaining), 3);
        chk("ar_rel_n3_buz", int'(buzzer), 1);

        state = 3'b110;
        cyc(1);
        cyc(2);
        chk("inv_led_on", int'(led_on), 0);
        chk("inv_buzzer", int'(buzzer), 0);
        chk("inv_remaining", int'(lock_remaining), 0);
        run_window(40, hi, ex);
        chk("inv_no_beep", hi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
